// File: rtl/seg7_pkg.sv
// Shared constants for the seg7 bus device: register offsets, CTRL layout and glyph table.
package seg7_pkg;

  localparam logic [1:0]  SEG7_OFF_VALUE   = 2'b00;
  localparam logic [1:0]  SEG7_OFF_CTRL    = 2'b01;
  localparam logic [31:0] SEG7_CTRL_RST    = 32'h0000_0001;
  localparam int          SEG7_CTRL_EN_BIT = 0;
  localparam int          SEG7_CTRL_DP_LSB = 8;
  localparam int          SEG7_CTRL_DP_MSB = 15;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG7_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [7:0] dp;
    logic       en;
  } seg7_ctrl_t;

  function automatic seg7_ctrl_t seg7_ctrl_unpack(input logic [31:0] w);
    seg7_ctrl_t c;
    c.en = w[SEG7_CTRL_EN_BIT];
    c.dp = w[SEG7_CTRL_DP_MSB:SEG7_CTRL_DP_LSB];
    return c;
  endfunction

  function automatic logic [31:0] seg7_ctrl_pack(input seg7_ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[SEG7_CTRL_EN_BIT] = c.en;
    w[SEG7_CTRL_DP_MSB:SEG7_CTRL_DP_LSB] = c.dp;
    return w;
  endfunction

endpackage

// File: rtl/seg7_bus_device_if.sv
// CPU-side bus between the bus controller (master) and the seg7 device (slave).
interface seg7_bus_device_if;
  logic        sel;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output sel, addr, wdata, we, input rdata);
  modport slave  (input sel, addr, wdata, we, output rdata);
endinterface

// File: rtl/seg7_hex_decoder.sv
// Nibble to active-low 7-segment glyph lookup.
import seg7_pkg::*;

module seg7_hex_decoder (
  input  logic [3:0] nib,
  output logic [6:0] glyph
);
  assign glyph = SEG7_GLYPHS[nib];
endmodule

// File: rtl/seg7_bus_device.sv
// Bus-mapped VALUE/CTRL registers driving an autonomously scanned 8-digit 7-seg display.
// Optional build macro SEG7_LEADING_BLANK_EN blanks leading zero digits (digit 0 always shown).
import seg7_pkg::*;

module seg7_bus_device #(
  parameter int SCAN_DIV   = 50000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_bus_device_if.slave      bus,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [31:0]   value;
  seg7_ctrl_t    ctrl;
  logic [CW-1:0] presc;
  logic [IW-1:0] idx;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          blank;
  logic          wr;

  assign wr = bus.sel & bus.we;

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      ctrl  <= seg7_ctrl_unpack(SEG7_CTRL_RST);
    end else if (wr) begin
      if (bus.addr == SEG7_OFF_VALUE) value <= bus.wdata;
      if (bus.addr == SEG7_OFF_CTRL)  ctrl  <= seg7_ctrl_unpack(bus.wdata);
    end
  end

  // Scan timing is free-running; EN only gates the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == CW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign nib = value[{idx, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nib   (nib),
    .glyph (glyph)
  );

`ifdef SEG7_LEADING_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_above;  // bit i: nibbles i..top are all zero

  always_comb begin
    zero_above = '0;
    zero_above[NUM_DIGITS-1] = (value[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      zero_above[i] = zero_above[i+1] & (value[4*i +: 4] == 4'h0);
  end

  assign blank = (idx != '0) & zero_above[idx];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || !ctrl.en) begin
      an  <= '1;
      seg <= '1;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= blank ? 8'hFF : {~ctrl.dp[idx], glyph};
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (bus.addr)
        SEG7_OFF_VALUE: bus.rdata = value;
        SEG7_OFF_CTRL:  bus.rdata = seg7_ctrl_pack(ctrl);
        default:        bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_bus_device.sv
// Random + directed bench for seg7_bus_device against a cycle-count based display model.
module tb_seg7_bus_device;
  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst;
  logic [7:0] an;
  logic [7:0] seg;

  seg7_bus_device_if bus ();

  seg7_bus_device #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .an  (an),
    .seg (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: display position derives from edges elapsed since reset.
  logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] m_val;
  logic        m_en;
  logic [7:0]  m_dp;
  int          m_n;
  int          m_idx;
  logic [3:0]  m_nib;
  logic [7:0]  exp_an, exp_seg;
  bit          armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_val = 32'h0; m_en = 1'b1; m_dp = 8'h00; m_n = 0;
      exp_an = 8'hFF; exp_seg = 8'hFF;
      armed = 1;
    end else begin
      m_idx = (m_n / SCAN_DIV) % 8;
      m_nib = m_val[4*m_idx +: 4];
      if (!m_en) begin
        exp_an = 8'hFF; exp_seg = 8'hFF;
      end else begin
        exp_an  = ~(8'h01 << m_idx);
        exp_seg = {~m_dp[m_idx], glyph_tab[m_nib]};
`ifdef SEG7_LEADING_BLANK_EN
        if (m_idx != 0 && (m_val >> (4*m_idx)) == 32'h0) exp_seg = 8'hFF;
`endif
      end
      m_n++;
      if (bus.sel && bus.we) begin
        if (bus.addr == 2'b00) m_val = bus.wdata;
        else if (bus.addr == 2'b01) begin
          m_en = bus.wdata[0];
          m_dp = bus.wdata[15:8];
        end
      end
    end
  end

  function automatic logic [31:0] exp_rdata();
    if (!bus.sel) return 32'h0;
    case (bus.addr)
      2'b00:   return m_val;
      2'b01:   return {16'h0, m_dp, 7'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    if (armed) begin
      chk("an", {24'h0, an}, {24'h0, exp_an});
      chk("seg", {24'h0, seg}, {24'h0, exp_seg});
      chk("rdata", bus.rdata, exp_rdata());
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wait_digit(input int d, output bit ok);
    ok = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #2;
      if (an == ~(8'h01 << d)) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_digit%0d: an=%h never selected digit", d, an);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [6:0] frame_exp [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
  bit ok;

  initial begin
    rst = 1'b1;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'b00; bus.wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    rst = 1'b0; bus.sel = 1'b1; bus.addr = 2'b01;
    #1 chk("rd_ctrl_rst", bus.rdata, 32'h0000_0001);
    @(posedge clk); #2;
    chk("first_an", {24'h0, an}, 32'hFE);
    chk("first_seg", {24'h0, seg}, 32'hC0);
    bus.sel = 1'b0;

    bus_write(2'b00, 32'h89AB_CDEF);
    for (int d = 0; d < 8; d++) begin
      wait_digit(d, ok);
      if (ok) chk($sformatf("frame_d%0d", d), {25'h0, seg[6:0]}, {25'h0, frame_exp[d]});
    end
    wait_digit(0, ok);
    if (ok) chk("frame_wrap", {24'h0, an}, 32'hFE);

    bus_write(2'b01, 32'h0000_0500);
    @(posedge clk); #2;
    chk("en0_an", {24'h0, an}, 32'hFF);
    chk("en0_seg", {24'h0, seg}, 32'hFF);
    bus_write(2'b01, 32'h0000_0501);
    wait_digit(0, ok); if (ok) chk("dp_d0", {31'h0, seg[7]}, 32'h0);
    wait_digit(1, ok); if (ok) chk("dp_d1", {31'h0, seg[7]}, 32'h1);
    wait_digit(2, ok); if (ok) chk("dp_d2", {31'h0, seg[7]}, 32'h0);
    @(negedge clk); bus.sel = 1'b1; bus.addr = 2'b01;
    #1 chk("rd_ctrl_501", bus.rdata, 32'h0000_0501);

    bus_write(2'b10, 32'hFFFF_FFFF);
    @(negedge clk); bus.sel = 1'b0; bus.we = 1'b1; bus.addr = 2'b00; bus.wdata = 32'h1234_5678;
    @(negedge clk); bus.we = 1'b0; bus.sel = 1'b1; bus.addr = 2'b10;
    #1 chk("rd_addr2", bus.rdata, 32'h0);
    bus.addr = 2'b00;
    #1 chk("rd_value_kept", bus.rdata, 32'h89AB_CDEF);
    bus.addr = 2'b01;
    #1 chk("rd_ctrl_kept", bus.rdata, 32'h0000_0501);
    bus.sel = 1'b0;
    #1 chk("rd_nosel", bus.rdata, 32'h0);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) == 0);
      bus.sel   = $urandom_range(0, 1);
      bus.we    = ($urandom_range(0, 7) == 0);
      bus.addr  = 2'($urandom_range(0, 3));
      bus.wdata = $urandom;
    end
    @(negedge clk);
    rst = 1'b0; bus.sel = 1'b0; bus.we = 1'b0;

    bus_write(2'b01, 32'h0000_0001);
    bus_write(2'b00, 32'hDEAD_BEEF);
    wait_digit(5, ok);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; bus.sel = 1'b1; bus.addr = 2'b00;
    #1 chk("midrst_value", bus.rdata, 32'h0);
    bus.addr = 2'b01;
    #1 chk("midrst_ctrl", bus.rdata, 32'h0000_0001);
    bus.sel = 1'b0;
    @(posedge clk); #2;
    chk("midrst_an", {24'h0, an}, 32'hFE);

    bus_write(2'b00, 32'h0000_0120);
`ifdef SEG7_LEADING_BLANK_EN
    wait_digit(0, ok); if (ok) chk("lb_d0", {25'h0, seg[6:0]}, 32'h40);
    wait_digit(1, ok); if (ok) chk("lb_d1", {25'h0, seg[6:0]}, 32'h24);
    wait_digit(2, ok); if (ok) chk("lb_d2", {25'h0, seg[6:0]}, 32'h79);
    for (int d = 3; d < 8; d++) begin
      wait_digit(d, ok);
      if (ok) chk($sformatf("lb_blank_d%0d", d), {24'h0, seg}, 32'hFF);
    end
    bus_write(2'b00, 32'h0);
    wait_digit(0, ok); if (ok) chk("lb_zero_d0", {25'h0, seg[6:0]}, 32'h40);
    wait_digit(1, ok); if (ok) chk("lb_zero_d1", {24'h0, seg}, 32'hFF);
`else
    wait_digit(2, ok); if (ok) chk("nolb_d2", {25'h0, seg[6:0]}, 32'h79);
    wait_digit(3, ok); if (ok) chk("nolb_d3", {24'h0, seg}, 32'hC0);
    wait_digit(7, ok); if (ok) chk("nolb_d7", {24'h0, seg}, 32'hC0);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
